// File: rtl/fir_out_quantizer.sv
// fir_out_quantizer: round / arithmetic-shift / saturate the FIR core's 32-bit
// stream down to 16 bits, buffer results in a small FIFO for sink backpressure,
// and keep sample / saturation / frame status counters.
module fir_out_quantizer #(
  parameter int pDATA_WIDTH = 32,
  parameter int pOUT_WIDTH  = 16,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   ss_tvalid,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  input  logic                   ss_tlast,
  output logic                   ss_tready,
  output logic                   sm_tvalid,
  output logic [pOUT_WIDTH-1:0]  sm_tdata,
  output logic                   sm_tlast,
  input  logic                   sm_tready,
  input  logic [4:0]             cfg_shift,
  input  logic                   cfg_round_en,
  input  logic                   cfg_sat_en,
  input  logic                   cnt_clr,
  output logic [15:0]            sample_cnt,
  output logic [15:0]            sat_cnt,
  output logic                   frame_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int VW = pDATA_WIDTH + 1;  // one guard bit so the rounding add cannot wrap

  // ---------------- stage 1 state ----------------
  logic                 s1_valid_q;
  logic signed [VW-1:0] s1_data_q;
  logic                 s1_last_q;
  logic                 s1_sat_en_q;

  // ---------------- stage 2 state ----------------
  logic                  s2_valid_q;
  logic [pOUT_WIDTH-1:0] s2_data_q;
  logic                  s2_last_q;
  logic                  s2_clamp_q;

  // ---------------- FIFO state ----------------
  logic [pOUT_WIDTH:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;
  logic [pOUT_WIDTH:0]   hold_q;  // last popped entry, shown while the FIFO is empty

  logic [15:0] sample_cnt_q, sat_cnt_q;
  logic        frame_done_q;

  logic accept, push, pop;
  logic [CW:0] occupancy;

  // Round-and-shift of the incoming sample, using the config present at acceptance
  logic signed [VW-1:0] rnd_add, v_sum, v_shift;
  always_comb begin
    rnd_add = '0;
    if (cfg_round_en && (cfg_shift != 5'd0))
      rnd_add = VW'(1) << (cfg_shift - 5'd1);
    v_sum   = $signed({ss_tdata[pDATA_WIDTH-1], ss_tdata}) + rnd_add;
    v_shift = v_sum >>> cfg_shift;
  end

  // Saturation: the value fits when all bits above the output sign bit match it
  logic [VW-pOUT_WIDTH:0] hi_bits;
  logic                   in_range;
  logic [pOUT_WIDTH-1:0]  q_data;
  logic                   q_clamp;
  always_comb begin
    hi_bits  = s1_data_q[VW-1:pOUT_WIDTH-1];
    in_range = (&hi_bits) || !(|hi_bits);
    q_data   = s1_data_q[pOUT_WIDTH-1:0];
    q_clamp  = 1'b0;
    if (s1_sat_en_q && !in_range) begin
      q_clamp = 1'b1;
      q_data  = s1_data_q[VW-1] ? {1'b1, {(pOUT_WIDTH-1){1'b0}}}
                                : {1'b0, {(pOUT_WIDTH-1){1'b1}}};
    end
  end

  // Handshakes and credit-based input ready (a same-cycle pop is not credited)
  always_comb begin
    occupancy = {1'b0, count_q} + (CW+1)'(s1_valid_q) + (CW+1)'(s2_valid_q);
    ss_tready = axis_rst_n && (occupancy < (CW+1)'(FIFO_DEPTH));
    accept    = ss_tvalid && ss_tready;
    sm_tvalid = (count_q != '0);
    push      = s2_valid_q;
    pop       = sm_tvalid && sm_tready;
    count_d   = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    {sm_tlast, sm_tdata} = sm_tvalid ? mem_q[rd_ptr_q] : hold_q;
  end

  // Two-stage quantizer pipeline; never stalls, each stage carries a valid bit
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_last_q   <= 1'b0;
      s1_sat_en_q <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_data_q   <= '0;
      s2_last_q   <= 1'b0;
      s2_clamp_q  <= 1'b0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_data_q   <= v_shift;
        s1_last_q   <= ss_tlast;
        s1_sat_en_q <= cfg_sat_en;
      end
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_data_q  <= q_data;
        s2_last_q  <= s1_last_q;
        s2_clamp_q <= q_clamp;
      end
    end
  end

  // FIFO storage; contents are only visible through count, so no reset needed
  always_ff @(posedge axis_clk) begin
    if (push) mem_q[wr_ptr_q] <= {s2_last_q, s2_data_q};
  end

  // FIFO pointers, count and the empty-hold register
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hold_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        hold_q   <= mem_q[rd_ptr_q];
      end
      count_q <= count_d;
    end
  end

  // Status counters (clear wins over increment) and the frame-done pulse
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      sample_cnt_q <= '0;
      sat_cnt_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      if (cnt_clr)  sample_cnt_q <= '0;
      else if (pop) sample_cnt_q <= sample_cnt_q + 16'd1;
      if (cnt_clr) sat_cnt_q <= '0;
      else if (push && s2_clamp_q && (sat_cnt_q != 16'hFFFF))
        sat_cnt_q <= sat_cnt_q + 16'd1;
      frame_done_q <= pop && sm_tlast;
    end
  end

  assign sample_cnt = sample_cnt_q;
  assign sat_cnt    = sat_cnt_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fir_out_quantizer.sv
// Directed bench for fir_out_quantizer with an expected-output scoreboard.
module tb_fir_out_quantizer;

  logic        axis_clk = 1'b0;
  logic        axis_rst_n;
  logic        ss_tvalid;
  logic [31:0] ss_tdata;
  logic        ss_tlast;
  logic        ss_tready;
  logic        sm_tvalid;
  logic [15:0] sm_tdata;
  logic        sm_tlast;
  logic        sm_tready;
  logic [4:0]  cfg_shift;
  logic        cfg_round_en;
  logic        cfg_sat_en;
  logic        cnt_clr;
  logic [15:0] sample_cnt;
  logic [15:0] sat_cnt;
  logic        frame_done;

  fir_out_quantizer dut (
    .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
    .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast), .ss_tready(ss_tready),
    .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast), .sm_tready(sm_tready),
    .cfg_shift(cfg_shift), .cfg_round_en(cfg_round_en), .cfg_sat_en(cfg_sat_en),
    .cnt_clr(cnt_clr), .sample_cnt(sample_cnt), .sat_cnt(sat_cnt), .frame_done(frame_done)
  );

  always #5 axis_clk = ~axis_clk;

  typedef struct {
    logic [31:0] d;
    logic        l;
    logic [15:0] e;
  } stim_t;

  stim_t       in_q[$];
  logic [16:0] sb[$];   // {tlast, expected data}
  int total = 0;
  int bad   = 0;
  int fd_pulses = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic add(input logic [31:0] d, input logic l, input logic [15:0] e);
    stim_t s;
    s.d = d; s.l = l; s.e = e;
    in_q.push_back(s);
  endtask

  task automatic drive_head();
    if (in_q.size() > 0) begin
      ss_tvalid = 1'b1;
      ss_tdata  = in_q[0].d;
      ss_tlast  = in_q[0].l;
    end else begin
      ss_tvalid = 1'b0;
    end
  endtask

  // One clock: record handshakes that will occur at the next edge, then advance.
  task automatic tick();
    logic [16:0] exp;
    logic        pop_last;
    pop_last = 1'b0;
    if (ss_tvalid && ss_tready) begin
      sb.push_back({in_q[0].l, in_q[0].e});
      in_q.delete(0);
      $display("in  data=%08h", ss_tdata);
    end
    if (sm_tvalid && sm_tready) begin
      chk("out_expected_present", {31'b0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        $display("out data=%04h last=%0b exp=%04h/%0b", sm_tdata, sm_tlast, exp[15:0], exp[16]);
        chk("out_data", {16'b0, sm_tdata}, {16'b0, exp[15:0]});
        chk("out_last", {31'b0, sm_tlast}, {31'b0, exp[16]});
      end
      pop_last = sm_tlast;
    end
    chk("occupancy_le_depth", {31'b0, sb.size() <= 4}, 32'd1);
    @(posedge axis_clk); #1;
    chk("frame_done", {31'b0, frame_done}, {31'b0, pop_last});
    if (frame_done) fd_pulses++;
    drive_head();
  endtask

  task automatic run_drain(input int budget);
    int n;
    n = 0;
    drive_head();
    while ((in_q.size() > 0 || sb.size() > 0) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_within_budget", {31'b0, n < budget}, 32'd1);
  endtask

  initial begin
    axis_rst_n = 1'b0; ss_tvalid = 1'b0; ss_tdata = '0; ss_tlast = 1'b0;
    sm_tready = 1'b0; cfg_shift = 5'd0; cfg_round_en = 1'b0; cfg_sat_en = 1'b1;
    cnt_clr = 1'b0;
    #3;
    chk("rst_ss_tready", {31'b0, ss_tready}, 32'd0);
    chk("rst_sm_tvalid", {31'b0, sm_tvalid}, 32'd0);
    chk("rst_sm_tdata", {16'b0, sm_tdata}, 32'd0);
    chk("rst_sm_tlast", {31'b0, sm_tlast}, 32'd0);
    chk("rst_sample_cnt", {16'b0, sample_cnt}, 32'd0);
    chk("rst_sat_cnt", {16'b0, sat_cnt}, 32'd0);
    chk("rst_frame_done", {31'b0, frame_done}, 32'd0);
    @(posedge axis_clk); #3;
    axis_rst_n = 1'b1;
    @(posedge axis_clk); #1;

    // Saturation at shift 0
    sm_tready = 1'b1;
    add(32'd1, 1'b0, 16'h0001);
    add(32'hFFFF_FFFF, 1'b0, 16'hFFFF);
    add(32'd40000, 1'b0, 16'h7FFF);
    add(-32'sd40000, 1'b0, 16'h8000);
    run_drain(60);
    chk("sat_cnt_after_clamps", {16'b0, sat_cnt}, 32'd2);
    chk("sample_cnt_4", {16'b0, sample_cnt}, 32'd4);

    // Round half up, shift 4
    cfg_shift = 5'd4; cfg_round_en = 1'b1;
    add(32'd24, 1'b0, 16'h0002);
    add(-32'sd24, 1'b0, 16'hFFFF);
    add(32'd23, 1'b0, 16'h0001);
    run_drain(60);
    // Truncating shift 4
    cfg_round_en = 1'b0;
    add(32'd24, 1'b0, 16'h0001);
    add(-32'sd24, 1'b0, 16'hFFFE);
    add(32'd23, 1'b0, 16'h0001);
    run_drain(60);
    // Extreme rounding must not wrap
    cfg_shift = 5'd31; cfg_round_en = 1'b1;
    add(32'h7FFF_FFFF, 1'b0, 16'h0001);
    run_drain(60);
    chk("sat_cnt_unchanged_round", {16'b0, sat_cnt}, 32'd2);

    // Wrap mode: low bits, no flag
    cfg_shift = 5'd0; cfg_round_en = 1'b0; cfg_sat_en = 1'b0;
    add(32'h0001_2345, 1'b0, 16'h2345);
    add(32'd40000, 1'b0, 16'h9C40);
    run_drain(60);
    chk("sat_cnt_unchanged_wrap", {16'b0, sat_cnt}, 32'd2);

    // Backpressure: only FIFO_DEPTH samples get in
    cfg_sat_en = 1'b1; sm_tready = 1'b0;
    for (int i = 1; i <= 6; i++) add(32'(i), 1'b0, 16'(i));
    drive_head();
    repeat (8) tick();
    chk("bp_accepted_4", in_q.size(), 32'd2);
    chk("bp_ss_tready_low", {31'b0, ss_tready}, 32'd0);
    chk("bp_sm_tvalid", {31'b0, sm_tvalid}, 32'd1);
    chk("bp_head_held", {16'b0, sm_tdata}, 32'd1);
    sm_tready = 1'b1;
    tick();
    chk("bp_ready_after_pop", {31'b0, ss_tready}, 32'd1);
    run_drain(60);
    chk("empty_sm_tvalid", {31'b0, sm_tvalid}, 32'd0);
    chk("empty_hold_data", {16'b0, sm_tdata}, 32'd6);
    tick();
    chk("empty_pop_ignored", {16'b0, sm_tdata}, 32'd6);
    chk("sample_cnt_19", {16'b0, sample_cnt}, 32'd19);

    // Frame with tlast on sample 11
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_sample_cnt", {16'b0, sample_cnt}, 32'd0);
    chk("clr_sat_cnt", {16'b0, sat_cnt}, 32'd0);
    fd_pulses = 0;
    for (int i = 1; i <= 11; i++) add(32'(i), (i == 11), 16'(i));
    run_drain(80);
    chk("frame_done_pulses", fd_pulses, 32'd1);
    chk("frame_sample_cnt", {16'b0, sample_cnt}, 32'd11);

    // Clear coincident with a handshake
    sm_tready = 1'b0;
    add(32'h55, 1'b0, 16'h0055);
    drive_head();
    repeat (4) tick();
    chk("clr_hs_valid", {31'b0, sm_tvalid}, 32'd1);
    sm_tready = 1'b1; cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_wins_sample_cnt", {16'b0, sample_cnt}, 32'd0);
    chk("clr_hs_sb_empty", sb.size(), 32'd0);

    // Asynchronous reset with buffered samples
    sm_tready = 1'b0;
    for (int i = 0; i < 3; i++) add(32'd40000, 1'b0, 16'h7FFF);
    drive_head();
    repeat (6) tick();
    chk("pre_rst_valid", {31'b0, sm_tvalid}, 32'd1);
    chk("pre_rst_sat_cnt", {16'b0, sat_cnt}, 32'd3);
    #2 axis_rst_n = 1'b0;
    #1;
    chk("arst_sm_tvalid", {31'b0, sm_tvalid}, 32'd0);
    chk("arst_sm_tdata", {16'b0, sm_tdata}, 32'd0);
    chk("arst_ss_tready", {31'b0, ss_tready}, 32'd0);
    chk("arst_sample_cnt", {16'b0, sample_cnt}, 32'd0);
    chk("arst_sat_cnt", {16'b0, sat_cnt}, 32'd0);
    chk("arst_frame_done", {31'b0, frame_done}, 32'd0);
    sb.delete(); in_q.delete(); ss_tvalid = 1'b0;
    repeat (2) @(posedge axis_clk);
    #3 axis_rst_n = 1'b1;
    #1;
    chk("post_rst_ss_tready", {31'b0, ss_tready}, 32'd1);
    @(posedge axis_clk); #1;
    sm_tready = 1'b1;
    repeat (10) tick();
    chk("post_rst_no_stale", {31'b0, sm_tvalid}, 32'd0);
    add(32'd7, 1'b1, 16'h0007);
    run_drain(60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
